// File: rtl/burst_config_memory.sv
// Configuration register file with random writes, a burst loader, a sequential
// clear engine and a sticky out-of-range error flag; every word is exposed in parallel.
module burst_config_memory #(
    parameter int unsigned DEPTH = 102,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [AW-1:0]          addr,
    input  logic                   write_enable,
    input  logic                   burst_start,
    input  logic [AW-1:0]          burst_len,
    input  logic                   data_valid,
    input  logic                   clear_start,
    input  logic                   err_clear,
    output logic [WIDTH-1:0]       data_out,
    output logic [DEPTH*WIDTH-1:0] all_data_out,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [AW-1:0]          remaining_q, remaining_d;
    logic [AW-1:0]          last_addr_q, last_addr_d;
    logic                   busy_d, done_d, err_set;
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;
    logic [DEPTH*WIDTH-1:0] mem_flat;
    logic [AW:0]            burst_end;
    logic                   burst_legal;
    logic                   addr_in_range;

    // Widened sum so a start near the top cannot wrap into a false pass
    assign burst_end     = {1'b0, addr} + {1'b0, burst_len};
    assign burst_legal   = (burst_len != '0) && (burst_end <= DEPTH_W);
    assign addr_in_range = ({1'b0, addr} < DEPTH_W);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; burst_start outranks clear_start outranks write_enable
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (burst_start) begin
                    if (burst_legal) state_d = S_BURST;
                end else if (clear_start) begin
                    state_d = S_CLEAR;
                end
            end
            S_BURST: if (data_valid && (remaining_q == AW'(1))) state_d = S_IDLE;
            S_CLEAR: if (ptr_q == LAST_IDX) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath control and next values of the registered outputs
    always_comb begin
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = data_in;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        last_addr_d = last_addr_q;
        err_set     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (burst_start) begin
                    if (burst_legal) begin
                        ptr_d       = addr;
                        remaining_d = burst_len;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (clear_start) begin
                    ptr_d = '0;
                end else if (write_enable) begin
                    if (addr_in_range) begin
                        mem_we      = 1'b1;
                        mem_waddr   = addr;
                        last_addr_d = addr;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (data_valid) begin
                    mem_we      = 1'b1;
                    last_addr_d = ptr_q;
                    ptr_d       = ptr_q + AW'(1);
                    remaining_d = remaining_q - AW'(1);
                    done_d      = (remaining_q == AW'(1));
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                ptr_d     = ptr_q + AW'(1);
                if (ptr_q == LAST_IDX) begin
                    done_d      = 1'b1;
                    last_addr_d = '0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control registers; a same-cycle error set wins over err_clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            remaining_q <= '0;
            last_addr_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            last_addr_q <= last_addr_d;
            busy        <= busy_d;
            done        <= done_d;
            if (err_set)        err <= 1'b1;
            else if (err_clear) err <= 1'b0;
        end
    end

    // Storage, one register word per address
    for (genvar j = 0; j < DEPTH; j++) begin : g_word
        localparam logic [AW-1:0] IDX = AW'(j);
        always_ff @(posedge clk or posedge reset) begin
            if (reset)                          mem_flat[j*WIDTH +: WIDTH] <= '0;
            else if (mem_we && mem_waddr == IDX) mem_flat[j*WIDTH +: WIDTH] <= mem_wdata;
        end
    end

    assign all_data_out = mem_flat;

    // Readback of the most recently written word
    always_comb begin
        data_out = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (last_addr_q == AW'(j)) data_out = mem_flat[j*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_burst_config_memory.sv
// Scoreboard bench for burst_config_memory: a cycle model queues the expected
// post-edge outputs, which are popped and compared one step after each edge.
module tb_burst_config_memory;

    localparam int unsigned DEPTH = 102;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned FW    = DEPTH * WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    addr;
    logic             write_enable;
    logic             burst_start;
    logic [AW-1:0]    burst_len;
    logic             data_valid;
    logic             clear_start;
    logic             err_clear;
    logic [WIDTH-1:0] data_out;
    logic [FW-1:0]    all_data_out;
    logic             busy;
    logic             done;
    logic             err;

    burst_config_memory #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .addr(addr),
        .write_enable(write_enable), .burst_start(burst_start), .burst_len(burst_len),
        .data_valid(data_valid), .clear_start(clear_start), .err_clear(err_clear),
        .data_out(data_out), .all_data_out(all_data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             err;
        logic [WIDTH-1:0] dout;
        logic [FW-1:0]    all;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_st;
    int               m_ptr, m_rem, m_last;
    logic             m_done, m_err;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        for (int j = 0; j < DEPTH; j++) e.all[j*WIDTH +: WIDTH] = m_mem[j];
        e.dout = m_mem[m_last];
        e.busy = (m_st != 0);
        e.done = m_done;
        e.err  = m_err;
        return e;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < DEPTH; j++) m_mem[j] = '0;
        m_st = 0; m_ptr = 0; m_rem = 0; m_last = 0; m_done = 0; m_err = 0;
    endtask

    // Behaviour of one rising edge given the inputs currently driven
    task automatic model_step();
        logic nd = 1'b0;
        logic es = 1'b0;
        case (m_st)
            0: begin
                if (burst_start) begin
                    if (burst_len != 0 && int'(addr) + int'(burst_len) <= DEPTH) begin
                        m_ptr = int'(addr); m_rem = int'(burst_len); m_st = 1;
                    end else es = 1'b1;
                end else if (clear_start) begin
                    m_ptr = 0; m_st = 2;
                end else if (write_enable) begin
                    if (int'(addr) < DEPTH) begin
                        m_mem[addr] = data_in; m_last = int'(addr);
                    end else es = 1'b1;
                end
            end
            1: if (data_valid) begin
                m_mem[m_ptr] = data_in; m_last = m_ptr; m_ptr++; m_rem--;
                if (m_rem == 0) begin m_st = 0; nd = 1'b1; end
            end
            default: begin
                m_mem[m_ptr] = '0; m_ptr++;
                if (m_ptr == DEPTH) begin m_st = 0; m_last = 0; nd = 1'b1; end
            end
        endcase
        m_done = nd;
        if (es) m_err = 1'b1;
        else if (err_clear) m_err = 1'b0;
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty got=0 exp=1", tag);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_busy"}, FW'(busy), FW'(e.busy));
            check_eq({tag, "_done"}, FW'(done), FW'(e.done));
            check_eq({tag, "_err"},  FW'(err),  FW'(e.err));
            check_eq({tag, "_dout"}, FW'(data_out), FW'(e.dout));
            check_eq({tag, "_all"},  all_data_out, e.all);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        sb.push_back(m_expect());
        @(posedge clk);
        #1;
        compare_front(tag);
    endtask

    task automatic idle_in();
        write_enable = 0; burst_start = 0; data_valid = 0;
        clear_start = 0; err_clear = 0; burst_len = '0; addr = '0; data_in = '0;
    endtask

    initial begin
        int bc;
        int guard;
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        sb.push_back(m_expect());
        compare_front("reset");
        check_eq("reset_all_zero", all_data_out, '0);
        reset = 1'b0;
        tick("post_reset");

        // Single write in range
        write_enable = 1; addr = 8'd5; data_in = 8'hA5;
        tick("wr5");
        idle_in();
        check_eq("wr5_dout", FW'(data_out), FW'(8'hA5));
        check_eq("wr5_slice", FW'(all_data_out[47:40]), FW'(8'hA5));

        // Out-of-range write, then clear the error
        write_enable = 1; addr = 8'd102; data_in = 8'hFF;
        tick("wr102");
        idle_in();
        check_eq("wr102_err", FW'(err), FW'(1'b1));
        check_eq("wr102_dout", FW'(data_out), FW'(8'hA5));
        err_clear = 1;
        tick("errclr");
        idle_in();
        check_eq("errclr_err", FW'(err), FW'(1'b0));

        // Burst at top of memory with one wait state
        burst_start = 1; addr = 8'd100; burst_len = 8'd2;
        tick("b100_start");
        idle_in();
        data_valid = 1; data_in = 8'h11; tick("b100_beat0");
        data_valid = 0; tick("b100_wait");
        data_valid = 1; data_in = 8'h22; tick("b100_beat1");
        idle_in();
        check_eq("b100_done", FW'(done), FW'(1'b1));
        check_eq("b100_dout", FW'(data_out), FW'(8'h22));
        check_eq("b100_m100", FW'(all_data_out[100*WIDTH +: WIDTH]), FW'(8'h11));
        tick("b100_after");
        check_eq("b100_done_gone", FW'(done), FW'(1'b0));

        // Illegal bursts: overrun and zero length
        burst_start = 1; addr = 8'd101; burst_len = 8'd2; tick("bad_overrun");
        idle_in();
        check_eq("bad_overrun_err", FW'(err), FW'(1'b1));
        err_clear = 1; tick("errclr2");
        burst_start = 1; err_clear = 1; addr = 8'd0; burst_len = 8'd0; tick("bad_zero");
        idle_in();
        check_eq("bad_zero_err", FW'(err), FW'(1'b1));
        tick("bad_zero_idle");
        err_clear = 1; tick("errclr3");
        idle_in();

        // Random legal burst with random wait states
        burst_start = 1; addr = 8'd40; burst_len = 8'd6; tick("rb_start");
        idle_in();
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 0) tick("rb_wait");
            data_valid = 1; data_in = WIDTH'($urandom_range(1, 255)); tick("rb_beat");
            data_valid = 0;
        end

        // Nonzero words, then clear with a colliding write
        for (int i = 0; i < 8; i++) begin
            write_enable = 1; addr = AW'($urandom_range(0, DEPTH - 1));
            data_in = WIDTH'($urandom_range(1, 255));
            tick("fill");
        end
        idle_in();
        clear_start = 1; write_enable = 1; addr = 8'd3; data_in = 8'h77;
        tick("clr_start");
        idle_in();
        bc = busy ? 1 : 0;
        guard = 0;
        while (!done && guard < 200) begin
            tick("clr_run");
            if (busy) bc++;
            guard++;
        end
        check_eq("clr_done_seen", FW'(done), FW'(1'b1));
        check_eq("clr_busy_cycles", FW'(bc), FW'(DEPTH));
        check_eq("clr_all_zero", all_data_out, '0);
        check_eq("clr_dout", FW'(data_out), FW'(0));
        tick("clr_after");

        // Reset in the middle of a burst
        write_enable = 1; addr = 8'd60; data_in = 8'h5C; tick("pre_rst_wr");
        idle_in();
        burst_start = 1; addr = 8'd10; burst_len = 8'd4; tick("rb2_start");
        idle_in();
        data_valid = 1; data_in = 8'hC1; tick("rb2_beat0");
        data_in = 8'hC2; tick("rb2_beat1");
        reset = 1'b1;
        #1;
        model_reset();
        sb.push_back(m_expect());
        compare_front("mid_reset");
        check_eq("mid_reset_all", all_data_out, '0);
        idle_in();
        #2 reset = 1'b0;
        repeat (3) tick("post_mid_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/burst_config_memory.md
Name: burst_config_memory

Overview:
- Parametrised configuration register file: DEPTH words of WIDTH bits, flat parallel readout of every word for downstream compute.
- Adds to single-word random writes:
  - a burst loader that streams consecutive words from a start address;
  - a sequential clear engine;
  - out-of-range error detection.
- Sits between the serial/SPI command decoder and the network core that consumes the configuration.

Parameters:
- DEPTH, 102, number of words (must be ≥ 2)
- WIDTH, 8, bits per word
- AW, 8, address width (2^AW ≥ DEPTH required)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- data_in  input  WIDTH  write/burst data
- addr  input  AW  single-write address, or burst start address
- write_enable  input  1  single-word write request
- burst_start  input  1  start burst at addr, length burst_len
- burst_len  input  AW  number of words in burst
- data_valid  input  1  burst data beat qualifier
- clear_start  input  1  start sequential clear of all words
- err_clear  input  1  clears sticky err
- data_out  output  WIDTH  word at last successfully written address
- all_data_out  output  DEPTH*WIDTH  word j on bits [j*WIDTH +: WIDTH]
- busy  output  1  high while in BURST or CLEAR
- done  output  1  one-cycle pulse on burst/clear completion
- err  output  1  sticky out-of-range/illegal-command flag

Behaviour:
- Reset (asynchronous, any state): all words 0, state IDLE, ptr/remaining/last_addr 0, data_out 0, busy 0, done 0, err 0.
- States: IDLE, BURST, CLEAR. busy is registered and equals (state != IDLE).
- Command priority in IDLE, same cycle: burst_start > clear_start > write_enable. Lower-priority commands in that cycle are dropped.
- IDLE single write:
  - write_enable with addr < DEPTH: mem[addr] <= data_in and last_addr <= addr.
  - addr ≥ DEPTH: no write, last_addr unchanged, err <= 1.
- IDLE burst_start:
  - Legality is checked with an AW+1-bit sum: burst_len ≠ 0 and addr + burst_len ≤ DEPTH.
  - Legal: ptr <= addr, remaining <= burst_len, go to BURST.
  - Illegal: err <= 1, stay in IDLE, no done pulse.
- BURST:
  - Each cycle with data_valid=1: mem[ptr] <= data_in, last_addr <= ptr, ptr+1, remaining-1.
  - Cycles with data_valid=0 are wait states with no change.
  - A beat with remaining==1 writes, returns to IDLE and drives done=1 in the following cycle.
  - write_enable, burst_start and clear_start are ignored while in BURST.
- CLEAR:
  - clear_start in IDLE sets ptr <= 0 and goes to CLEAR.
  - One word is zeroed per cycle, ptr 0..DEPTH-1; the final word's write returns to IDLE with done next cycle. CLEAR occupies exactly DEPTH cycles.
  - At exit, last_addr <= 0.
  - All commands and data_valid are ignored while in CLEAR.
- done: registered, high exactly one cycle, the cycle after the final write. The cycle done is high is also the first IDLE cycle (busy=0), and new commands are accepted then.
- err:
  - Set has priority over err_clear in the same cycle.
  - Otherwise err_clear drives err to 0.
- data_out: combinational mem[last_addr]. It reflects a write in the cycle after the write edge.
- all_data_out: combinational concatenation of all words. Updates after each write edge; no extra latency.
- Reset mid-BURST or mid-CLEAR: abort immediately, all memory zero, no done pulse.

Test Plan:
- Reset -> all_data_out all zero, busy=0, done=0, err=0; write_enable addr=5 data=0xA5 -> next cycle data_out=0xA5, all_data_out[47:40]=0xA5.
- write_enable addr=102 data=0xFF -> err=1, all_data_out unchanged, data_out still 0xA5; err_clear -> err=0.
- burst_start addr=100 len=2; data_valid with 0x11, one idle cycle, then 0x22 -> mem[100]=0x11, mem[101]=0x22, busy high 3 cycles, done high for one cycle right after the 0x22 edge, data_out=0x22.
- burst_start addr=101 len=2; separately burst_start addr=0 len=0 -> each sets err=1, busy stays 0, no memory change, no done.
- Load nonzero words, then clear_start with write_enable also asserted in the same cycle -> the write is dropped, busy for 102 cycles, then all words 0, done pulse, data_out=0.
- burst_start addr=10 len=4, reset asserted after 2 beats -> immediate IDLE, busy=0, all words 0, no done pulse.
